// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: walks the program counter through the
// synchronous program ROM and assembles 1- and 2-byte instructions. It hands
// them to the execute stage over valid/ready and applies taken jumps by
// loading the counter.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [1:0]  LONG_PFX = 2'b10,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        rom_data,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_value,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_opcode,
  output logic [3:0]        instr_operand,
  output logic [ADDR_W-1:0] instr_target,
  input  logic              jump_take,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_ADDR1,
    S_BYTE1,
    S_ADDR2,
    S_BYTE2,
    S_ISSUE,
    S_JUMP,
    S_HALT
  } state_t;

  state_t state;
  state_t nxt;
  logic   handshake;

  // pc_in only addresses the ROM; the sequencer never inspects it.
  logic   unused_pc;
  assign unused_pc = ^pc_in;

  assign handshake = instr_valid && instr_ready;

  // Next-state selection; outputs are registered from this so that every
  // control output is a decode of the state being entered.
  always_comb begin
    nxt = state;
    case (state)
      S_ADDR1: nxt = S_BYTE1;
      S_BYTE1: nxt = (rom_data[7:6] == LONG_PFX) ? S_ADDR2 : S_ISSUE;
      S_ADDR2: nxt = S_BYTE2;
      S_BYTE2: nxt = S_ISSUE;
      S_ISSUE: begin
        if (handshake) begin
          if (instr_opcode == HALT_OPC)
            nxt = S_HALT;
          else if ((instr_opcode[3:2] == LONG_PFX) && jump_take)
            nxt = S_JUMP;
          else
            nxt = S_ADDR1;
        end
      end
      S_JUMP:  nxt = S_ADDR1;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_ADDR1;
    endcase
  end

  // State register, registered Moore outputs and instruction field capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_ADDR1;
      pc_enable     <= 1'b0;
      pc_load       <= 1'b0;
      pc_value      <= '0;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_target  <= '0;
      halted        <= 1'b0;
    end else begin
      state       <= nxt;
      pc_enable   <= (nxt == S_BYTE1) || (nxt == S_BYTE2);
      pc_load     <= (nxt == S_JUMP);
      pc_value    <= (nxt == S_JUMP) ? instr_target : '0;
      instr_valid <= (nxt == S_ISSUE);
      halted      <= (nxt == S_HALT);

      if (state == S_BYTE1) begin
        instr_opcode  <= rom_data[7:4];
        instr_operand <= rom_data[3:0];
        if (rom_data[7:6] != LONG_PFX)
          instr_target <= '0;
      end

      if (state == S_BYTE2)
        instr_target <= ADDR_W'({instr_operand, rom_data});
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the 12-bit program counter and the
// synchronous ROM around the DUT and checks every cycle against a
// program-walk reference model built from the fetch timing rules.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W = 12;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] pc_in;
  logic [7:0]        rom_data;
  logic              pc_enable;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_value;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_opcode;
  logic [3:0]        instr_operand;
  logic [ADDR_W-1:0] instr_target;
  logic              jump_take;
  logic              halted;

  fetch_sequencer #(
    .ADDR_W  (12),
    .LONG_PFX(2'b10),
    .HALT_OPC(4'hF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .rom_data     (rom_data),
    .pc_enable    (pc_enable),
    .pc_load      (pc_load),
    .pc_value     (pc_value),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_target (instr_target),
    .jump_take    (jump_take),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]        rom [4096];

  // Counter environment: DUT outputs of the cycle just observed.
  logic              s_en;
  logic              s_load;
  logic [ADDR_W-1:0] s_val;

  // Reference model: address of the instruction being fetched, the cycle its
  // fetch began, halt status and the pending counter load.
  logic [ADDR_W-1:0] m_pc;
  int                m_a1;
  bit                m_halted;
  int                m_load_cyc;
  logic [ADDR_W-1:0] m_load_val;

  int cyc;
  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit is_long(input logic [7:0] b);
    return b[7:6] == 2'b10;
  endfunction

  // Issue begins 2 cycles after the fetch start for a 1-byte instruction and
  // 4 cycles after for a 2-byte one.
  function automatic bit exp_valid();
    int lat;
    lat = is_long(rom[m_pc]) ? 4 : 2;
    return !m_halted && (cyc >= m_a1 + lat);
  endfunction

  task automatic check_cycle();
    logic [7:0]        b1;
    logic [7:0]        b2;
    bit                lg;
    bit                ev;
    bit                een;
    bit                eld;
    logic [ADDR_W-1:0] tgt;
    b1  = rom[m_pc];
    b2  = rom[m_pc + 12'd1];
    lg  = is_long(b1);
    tgt = lg ? {b1[3:0], b2} : 12'h000;
    ev  = exp_valid();
    een = !m_halted && ((cyc == m_a1 + 1) || (lg && (cyc == m_a1 + 3)));
    eld = (cyc == m_load_cyc);
    check("instr_valid", 32'(instr_valid), 32'(ev));
    check("pc_enable", 32'(pc_enable), 32'(een));
    check("pc_load", 32'(pc_load), 32'(eld));
    check("pc_value", 32'(pc_value), eld ? 32'(m_load_val) : 32'd0);
    check("halted", 32'(halted), 32'(m_halted));
    if (ev) begin
      check("opcode", 32'(instr_opcode), 32'(b1[7:4]));
      check("operand", 32'(instr_operand), 32'(b1[3:0]));
      check("target", 32'(instr_target), 32'(tgt));
    end
    if (!m_halted && (cyc == m_a1))
      check("fetch_addr", 32'(pc_in), 32'(m_pc));
  endtask

  // One clock: update counter and ROM after the edge, then check the DUT.
  task automatic tick();
    @(posedge clk);
    #1;
    rom_data = rom[pc_in];
    if (reset)       pc_in = '0;
    else if (s_load) pc_in = s_val;
    else if (s_en)   pc_in = pc_in + 12'd1;
    @(negedge clk);
    cyc++;
    check_cycle();
    s_en   = pc_enable;
    s_load = pc_load;
    s_val  = pc_value;
  endtask

  // Apply inputs for the current cycle and advance the model accordingly.
  task automatic drive(input bit rst, input bit rdy, input bit jt);
    logic [7:0] b1;
    logic [7:0] b2;
    reset       = rst;
    instr_ready = rdy;
    jump_take   = jt;
    if (rst) begin
      m_pc       = '0;
      m_a1       = cyc + 1;
      m_halted   = 1'b0;
      m_load_cyc = -1;
    end else if (exp_valid() && rdy) begin
      b1 = rom[m_pc];
      b2 = rom[m_pc + 12'd1];
      if (b1[7:4] == 4'hF) begin
        m_halted = 1'b1;
      end else if (is_long(b1) && jt) begin
        m_load_cyc = cyc + 1;
        m_load_val = {b1[3:0], b2};
        m_pc       = {b1[3:0], b2};
        m_a1       = cyc + 2;
      end else begin
        m_pc = m_pc + (is_long(b1) ? 12'd2 : 12'd1);
        m_a1 = cyc + 1;
      end
    end
  endtask

  task automatic hold_reset();
    tick();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input bit rdy, input bit jt);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, rdy, jt);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  initial begin
    bit found;
    int hc;
    logic [7:0] b;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    instr_ready = 1'b0;
    jump_take   = 1'b0;
    pc_in    = '0;
    rom_data = '0;
    s_en   = 1'b0;
    s_load = 1'b0;
    s_val  = '0;
    m_pc       = '0;
    m_a1       = 1;
    m_halted   = 1'b0;
    m_load_cyc = -1;
    m_load_val = '0;
    clear_rom();

    // 1-byte fetch, taken jump to 12'hA5C, halt held for 20+ cycles.
    hold_reset();
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'h8A; rom[2] = 8'h5C; rom[12'hA5C] = 8'hF0;
    hold_reset();
    run(35, 1'b1, 1'b1);

    // Same jump not taken: fetch continues from address 3.
    hold_reset();
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'h8A; rom[2] = 8'h5C; rom[3] = 8'hF0;
    hold_reset();
    run(20, 1'b1, 1'b0);

    // Backpressure: five stalled issue cycles, accepted on the sixth.
    hold_reset();
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'hF0;
    hold_reset();
    run(7, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0);

    // Reset while the second byte of a jump-class instruction is captured.
    hold_reset();
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'h8A; rom[2] = 8'h5C; rom[3] = 8'hF0;
    hold_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!found && (m_pc == 12'd1) && (cyc == m_a1 + 3)) begin
        found = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
      end else begin
        drive(1'b0, 1'b1, 1'b0);
      end
    end
    check("reached_byte2", 32'(found), 32'd1);
    run(20, 1'b1, 1'b0);

    // Jump-class instruction at 12'hFFF takes its second byte from 12'h000.
    hold_reset();
    clear_rom();
    rom[0] = 8'h8F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h9A; rom[12'hA8F] = 8'hF0;
    hold_reset();
    run(30, 1'b1, 1'b1);

    // Random program with random ready, jump decisions and resets.
    hold_reset();
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'hE;
      rom[i] = b;
    end
    for (int i = 0; i < 8; i++) rom[$urandom_range(0, 4095)] = 8'hF0;
    hold_reset();
    hc = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (m_halted) hc++;
      if (hc > 3 || $urandom_range(0, 299) == 0) begin
        hc = 0;
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        drive(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch controller for the 12-bit program counter.
- Consumes the counter's address output and the synchronous program ROM byte.
- Assembles 1- and 2-byte instructions and hands them to the execute stage over a valid/ready handshake.
- Drives the counter's enable, load and load-value inputs to step through the program and apply taken jumps.

Parameters:
- ADDR_W, 12, program address width; matches the counter width.
- LONG_PFX, 2'b10, opcode[3:2] value that marks a 2-byte (jump-class) instruction.
- HALT_OPC, 4'hF, opcode that stops fetching.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  current counter value; also drives the ROM address.
- rom_data  in  8  ROM byte; valid one cycle after pc_in is stable.
- pc_enable  out  1  counter increment request.
- pc_load  out  1  counter load request.
- pc_value  out  ADDR_W  counter load value.
- instr_valid  out  1  instruction available to execute.
- instr_ready  in  1  execute accepts the instruction.
- instr_opcode  out  4  opcode, rom byte1[7:4].
- instr_operand  out  4  operand, rom byte1[3:0].
- instr_target  out  ADDR_W  jump target, {operand, byte2}; 0 for 1-byte instructions.
- jump_take  in  1  execute's taken-jump decision; sampled only on handshake.
- halted  out  1  high once HALT_OPC has been accepted.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (also mid-operation):
  - state=S_ADDR1.
  - All outputs 0: instr_valid=0, pc_enable=0, pc_load=0, pc_value=0, opcode/operand/target=0, halted=0.
  - Any partially assembled instruction is discarded.
  - The counter shares reset, so fetch restarts at address 0.
- Outputs pc_enable, pc_load and instr_valid are Moore decodes of the registered state. No combinational path from inputs to these outputs.
- States:
  - S_ADDR1: pc_in presented to ROM. Next state S_BYTE1.
  - S_BYTE1: rom_data valid; latch opcode/operand; pc_enable=1 for exactly this cycle.
    - opcode[3:2]==LONG_PFX: next S_ADDR2.
    - Otherwise: clear target; next S_ISSUE.
  - S_ADDR2: incremented pc_in presented. Next S_BYTE2.
  - S_BYTE2: latch target={operand, rom_data}; pc_enable=1 this cycle. Next S_ISSUE.
  - S_ISSUE: instr_valid=1. Opcode, operand and target are held stable until instr_valid&&instr_ready.
    - On handshake with opcode==HALT_OPC: next S_HALT.
    - On handshake, jump-class opcode with jump_take=1: next S_JUMP.
    - On handshake otherwise: next S_ADDR1.
    - No handshake: remain in S_ISSUE.
  - S_JUMP: pc_load=1, pc_value=target for exactly one cycle. Next S_ADDR1.
  - S_HALT: halted=1, instr_valid=0, no enable/load. Left only by reset.
- jump_take on a 1-byte instruction, or outside the handshake cycle, is ignored.
- pc_value is 0 whenever pc_load=0.
- pc_enable and pc_load are never high in the same cycle.
- Latency:
  - 1-byte instruction: S_ADDR1 to instr_valid is 2 cycles.
  - 2-byte instruction: S_ADDR1 to instr_valid is 4 cycles.
  - Minimum issue interval: 3 cycles (1-byte), 5 cycles (2-byte), plus 1 cycle when a jump is taken.
- Address wrap: the counter wraps 12'hFFF to 12'h000 naturally. A 2-byte instruction at 12'hFFF takes byte2 from 12'h000; no special handling.
- instr_ready held high with no valid: no effect.

Test Plan:
- Reset release, ROM[0]=8'h35, ready=1: instr_valid in the 3rd cycle after reset deasserts, with opcode=3, operand=5, target=0. pc_enable pulses once, and pc_in becomes 1.
- ROM[1..2]=8'h8A,8'h5C, ready=1, jump_take=1:
  - instr_target=12'hA5C.
  - pc_enable pulses twice.
  - pc_load=1 with pc_value=12'hA5C for one cycle.
  - Next fetch comes from 12'hA5C.
- Same jump with jump_take=0: no pc_load, and the next fetch is from address 3.
- Backpressure: hold instr_ready=0 for 5 cycles in S_ISSUE. instr_valid stays 1, fields stay stable and pc_enable stays 0. Accept on the 6th cycle.
- ROM byte 8'hF0 accepted: halted=1 and remains so for 20 cycles, with no pc_enable or pc_load. Reset then clears halted, and a fetch from address 0 follows.
- Two cases:
  - Reset asserted in S_BYTE2: instr_valid stays 0 and a 1-byte fetch restarts at address 0.
  - Jump-class instruction at 12'hFFF: byte2 is read from 12'h000.
